// File: rtl/t5_lsu.sv
// -----------------------------------------------------------------------------
// t5_lsu -- load/store unit with a single-outstanding Wishbone master port.
//
// Accepts one memory request at a time from the pipeline, checks it for an
// illegal funct3 or a misaligned address, and either raises an exception
// straight away or runs one Wishbone cycle.  Load data is shifted down to
// bit 0 and sign/zero extended from the access size.
//
// Ports
//   sclk, srst             clock, asynchronous active-low reset
//   sena                   pipeline enable, gates request acceptance only
//   req_vld/wre/fn3/adr/dat request from the pipeline (held while stalled)
//   dwb_adr/dto/sel/wre/stb Wishbone master outputs (lane-aligned address)
//   dwb_dti/ack/err        Wishbone slave responses
//   lsu_stall              hold-pipeline indication (combinational)
//   lsu_vld, lsu_dat       completion pulse and extended load result
//   lsu_exc, lsu_cause     exception pulse and mcause code
// -----------------------------------------------------------------------------
module t5_lsu #(
  parameter int XLEN = 32,
  parameter int TMO  = 255
) (
  input  logic                            sclk,
  input  logic                            srst,
  input  logic                            sena,
  input  logic                            req_vld,
  input  logic                            req_wre,
  input  logic [2:0]                      req_fn3,
  input  logic [XLEN-1:0]                 req_adr,
  input  logic [XLEN-1:0]                 req_dat,
  output logic [XLEN-$clog2(XLEN/8)-1:0]  dwb_adr,
  output logic [XLEN-1:0]                 dwb_dto,
  output logic [XLEN/8-1:0]               dwb_sel,
  output logic                            dwb_wre,
  output logic                            dwb_stb,
  input  logic [XLEN-1:0]                 dwb_dti,
  input  logic                            dwb_ack,
  input  logic                            dwb_err,
  output logic                            lsu_stall,
  output logic                            lsu_vld,
  output logic [XLEN-1:0]                 lsu_dat,
  output logic                            lsu_exc,
  output logic [3:0]                      lsu_cause
);

  localparam int NB       = XLEN / 8;
  localparam int SW       = $clog2(NB);
  localparam int CW       = (TMO > 1) ? $clog2(TMO + 1) : 1;
  localparam int TMO_LAST = (TMO > 0) ? TMO - 1 : 0;

  localparam logic [3:0] CAUSE_ILL    = 4'd2;
  localparam logic [3:0] CAUSE_LD_MIS = 4'd4;
  localparam logic [3:0] CAUSE_LD_ACC = 4'd5;
  localparam logic [3:0] CAUSE_ST_MIS = 4'd6;
  localparam logic [3:0] CAUSE_ST_ACC = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [XLEN-SW-1:0]  adr_q, adr_d;
  logic [SW-1:0]       off_q, off_d;
  logic [NB-1:0]       sel_q, sel_d;
  logic [XLEN-1:0]     dto_q, dto_d;
  logic                wre_q, wre_d;
  logic                stb_q, stb_d;
  logic [2:0]          fn3_q, fn3_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                vld_q, vld_d;
  logic                exc_q, exc_d;
  logic [3:0]          cause_q, cause_d;
  logic [XLEN-1:0]     dat_q, dat_d;

  // Request decode
  logic                req_ill;
  logic                req_mis;
  logic [7:0]          req_mask;
  logic [NB-1:0]       req_sel;
  logic [XLEN-1:0]     req_dto;

  // Load data alignment
  logic [XLEN-1:0]     ld_shift;
  logic [XLEN-1:0]     ld_msk;
  logic                ld_sbit;
  logic [XLEN-1:0]     ld_ext;
  logic                tmo_hit;

  // ---------------------------------------------------------------------------
  // Request decode: legality, alignment, byte-lane select and store data
  // replicated across all lanes so the slave can pick any lane.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    req_mis  = 1'b0;
    req_mask = 8'h00;
    req_dto  = req_dat;
    req_ill  = (req_fn3 == 3'b111) ||
               (req_wre && req_fn3[2]) ||
               ((XLEN == 32) && ((req_fn3 == 3'b011) || (req_fn3 == 3'b110)));
    case (req_fn3[1:0])
      2'b00: begin
        req_mask = 8'h01;
        for (int i = 0; i < NB; i++) req_dto[8*i +: 8] = req_dat[7:0];
      end
      2'b01: begin
        req_mask = 8'h03;
        req_mis  = req_adr[0];
        for (int i = 0; i < NB / 2; i++) req_dto[16*i +: 16] = req_dat[15:0];
      end
      2'b10: begin
        req_mask = 8'h0F;
        req_mis  = |req_adr[1:0];
        for (int i = 0; i < NB / 4; i++) req_dto[32*i +: 32] = req_dat[31:0];
      end
      default: begin
        req_mask = 8'hFF;
        req_mis  = |req_adr[2:0];
        req_dto  = req_dat;
      end
    endcase
    req_sel = NB'(req_mask << req_adr[SW-1:0]);
  end

  // ---------------------------------------------------------------------------
  // Load result: move the addressed lanes to bit 0, then extend from the
  // access size.  fn3[2] selects zero extension.
  // ---------------------------------------------------------------------------
  always_comb begin
    ld_shift = dwb_dti >> {off_q, 3'b000};
    case (fn3_q[1:0])
      2'b00:   begin ld_msk = XLEN'(8'hFF);         ld_sbit = ld_shift[7];      end
      2'b01:   begin ld_msk = XLEN'(16'hFFFF);      ld_sbit = ld_shift[15];     end
      2'b10:   begin ld_msk = XLEN'(32'hFFFF_FFFF); ld_sbit = ld_shift[31];     end
      default: begin ld_msk = '1;                   ld_sbit = ld_shift[XLEN-1]; end
    endcase
    ld_ext = (ld_shift & ld_msk) | ({XLEN{ld_sbit & ~fn3_q[2]}} & ~ld_msk);
  end

  // The counter holds the number of completed stb-high cycles, so it equals
  // TMO-1 during the TMO-th cycle; the edge ending that cycle times out.
  assign tmo_hit = (TMO > 0) && (cnt_q == CW'(TMO_LAST));

  // ---------------------------------------------------------------------------
  // Next-state logic.  Result outputs default to 0 so they are pulses that
  // live only in DONE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    off_d   = off_q;
    sel_d   = sel_q;
    dto_d   = dto_q;
    wre_d   = wre_q;
    stb_d   = stb_q;
    fn3_d   = fn3_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    exc_d   = 1'b0;
    cause_d = 4'd0;
    dat_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (sena && req_vld) begin
          if (req_ill || req_mis) begin
            // Faulting request: no bus cycle, report straight away.
            state_d = S_DONE;
            exc_d   = 1'b1;
            if (req_ill)      cause_d = CAUSE_ILL;
            else if (req_wre) cause_d = CAUSE_ST_MIS;
            else              cause_d = CAUSE_LD_MIS;
          end else begin
            state_d = S_WAIT;
            adr_d   = req_adr[XLEN-1:SW];
            off_d   = req_adr[SW-1:0];
            sel_d   = req_sel;
            dto_d   = req_dto;
            wre_d   = req_wre;
            fn3_d   = req_fn3;
            stb_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end

      S_WAIT: begin
        // err (or a timeout) takes priority over a simultaneous ack.
        if (dwb_err || tmo_hit) begin
          state_d = S_DONE;
          stb_d   = 1'b0;
          exc_d   = 1'b1;
          cause_d = wre_q ? CAUSE_ST_ACC : CAUSE_LD_ACC;
        end else if (dwb_ack) begin
          state_d = S_DONE;
          stb_d   = 1'b0;
          vld_d   = 1'b1;
          dat_d   = wre_q ? '0 : ld_ext;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      off_q   <= '0;
      sel_q   <= '0;
      dto_q   <= '0;
      wre_q   <= 1'b0;
      stb_q   <= 1'b0;
      fn3_q   <= 3'd0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      exc_q   <= 1'b0;
      cause_q <= 4'd0;
      dat_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q <= state_d;
      adr_q   <= adr_d;
      off_q   <= off_d;
      sel_q   <= sel_d;
      dto_q   <= dto_d;
      wre_q   <= wre_d;
      stb_q   <= stb_d;
      fn3_q   <= fn3_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      exc_q   <= exc_d;
      cause_q <= cause_d;
      dat_q   <= dat_d;
    end
  end

  assign dwb_adr   = adr_q;
  assign dwb_sel   = sel_q;
  assign dwb_dto   = dto_q;
  assign dwb_wre   = wre_q;
  assign dwb_stb   = stb_q;
  assign lsu_vld   = vld_q;
  assign lsu_exc   = exc_q;
  assign lsu_cause = cause_q;
  assign lsu_dat   = dat_q;
  assign lsu_stall = (state_q == S_WAIT) || ((state_q == S_IDLE) && sena && req_vld);

endmodule

// File: tb/tb_t5_lsu.sv
// -----------------------------------------------------------------------------
// tb_t5_lsu -- scoreboard bench for t5_lsu.
// Two instances: index 0 is XLEN=32 with TMO=8, index 1 is XLEN=64 with the
// default timeout.  The driver acts as the pipeline and the Wishbone slave,
// pushing expected results from a reference model; per-instance monitors pop
// and compare whenever lsu_vld or lsu_exc appears.
// -----------------------------------------------------------------------------
module tb_t5_lsu;

  typedef struct {
    bit        vld;
    bit        exc;
    bit [3:0]  cause;
    bit [63:0] dat;
  } res_t;

  typedef struct {
    bit        ok;
    bit [7:0]  sel;
    bit [63:0] dto;
    bit [63:0] badr;
    res_t      res;
  } mdl_t;

  logic sclk = 1'b0;
  logic srst = 1'b0;

  logic [1:0]       sena, r_vld, r_wre, i_ack, i_err;
  logic [1:0][2:0]  r_fn3;
  logic [1:0][63:0] r_adr, r_dat, i_dti;

  wire [29:0] a0_adr;
  wire [60:0] a1_adr;
  wire [3:0]  a0_sel;
  wire [7:0]  a1_sel;
  wire [31:0] a0_dto, a0_dat;
  wire [63:0] a1_dto, a1_dat;
  wire [1:0]  o_wre, o_stb, o_stall, o_vld, o_exc;
  wire [1:0][3:0] o_cause;

  int total = 0;
  int bad   = 0;
  res_t exp_q0[$];
  res_t exp_q1[$];

  always #5 sclk = ~sclk;

  t5_lsu #(.XLEN(32), .TMO(8)) u_dut32 (
    .sclk(sclk), .srst(srst), .sena(sena[0]), .req_vld(r_vld[0]), .req_wre(r_wre[0]),
    .req_fn3(r_fn3[0]), .req_adr(r_adr[0][31:0]), .req_dat(r_dat[0][31:0]),
    .dwb_adr(a0_adr), .dwb_dto(a0_dto), .dwb_sel(a0_sel), .dwb_wre(o_wre[0]),
    .dwb_stb(o_stb[0]), .dwb_dti(i_dti[0][31:0]), .dwb_ack(i_ack[0]), .dwb_err(i_err[0]),
    .lsu_stall(o_stall[0]), .lsu_vld(o_vld[0]), .lsu_dat(a0_dat), .lsu_exc(o_exc[0]),
    .lsu_cause(o_cause[0])
  );

  t5_lsu #(.XLEN(64)) u_dut64 (
    .sclk(sclk), .srst(srst), .sena(sena[1]), .req_vld(r_vld[1]), .req_wre(r_wre[1]),
    .req_fn3(r_fn3[1]), .req_adr(r_adr[1]), .req_dat(r_dat[1]),
    .dwb_adr(a1_adr), .dwb_dto(a1_dto), .dwb_sel(a1_sel), .dwb_wre(o_wre[1]),
    .dwb_stb(o_stb[1]), .dwb_dti(i_dti[1]), .dwb_ack(i_ack[1]), .dwb_err(i_err[1]),
    .lsu_stall(o_stall[1]), .lsu_vld(o_vld[1]), .lsu_dat(a1_dat), .lsu_exc(o_exc[1]),
    .lsu_cause(o_cause[1])
  );

  function automatic logic [63:0] g_adr(int k);
    return (k == 0) ? 64'(a0_adr) : 64'(a1_adr);
  endfunction
  function automatic logic [63:0] g_sel(int k);
    return (k == 0) ? 64'(a0_sel) : 64'(a1_sel);
  endfunction
  function automatic logic [63:0] g_dto(int k);
    return (k == 0) ? 64'(a0_dto) : a1_dto;
  endfunction
  function automatic logic [63:0] g_dat(int k);
    return (k == 0) ? 64'(a0_dat) : a1_dat;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the access should do, from the architectural rules.
  function automatic mdl_t model(int xlen, bit wre, bit [2:0] fn3, bit [63:0] adr_in,
                                 bit [63:0] dat_in, bit [63:0] dti_in, int kind);
    mdl_t m;
    bit [63:0] xm, msk, adr, dat, dti, piece, v;
    int nb, size, off;
    bit ill;
    xm    = (xlen == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
    adr   = adr_in & xm;
    dat   = dat_in & xm;
    dti   = dti_in & xm;
    nb    = xlen / 8;
    size  = 1 << fn3[1:0];
    off   = int'(adr[2:0]) % nb;
    msk   = (size == 8) ? '1 : ((64'd1 << (8 * size)) - 64'd1);
    ill   = (fn3 == 3'b111) || ((xlen == 32) && (fn3 == 3'b011 || fn3 == 3'b110)) ||
            (wre && fn3[2]);
    m.ok = 0; m.res.vld = 0; m.res.exc = 0; m.res.cause = 0; m.res.dat = 0;
    m.badr = adr >> ((xlen == 64) ? 3 : 2);
    m.sel  = 8'((((1 << size) - 1) << off) & ((1 << nb) - 1));
    piece  = dat & msk;
    m.dto  = 0;
    for (int j = 0; j < nb / size; j++) m.dto |= piece << (8 * size * j);
    m.dto &= xm;
    if (ill) begin
      m.res.exc = 1; m.res.cause = 2;
    end else if ((int'(adr[2:0]) % size) != 0) begin
      m.res.exc = 1; m.res.cause = wre ? 4'd6 : 4'd4;
    end else begin
      m.ok = 1;
      if (kind == 0) begin
        m.res.vld = 1;
        if (!wre) begin
          v = (dti >> (8 * off)) & msk;
          if (!fn3[2] && size < 8 && ((v >> (8 * size - 1)) & 64'd1) == 64'd1) v |= ~msk;
          m.res.dat = v & xm;
        end
      end else begin
        m.res.exc = 1; m.res.cause = wre ? 4'd7 : 4'd5;
      end
    end
    return m;
  endfunction

  task automatic push(int k, res_t r);
    if (k == 0) exp_q0.push_back(r);
    else        exp_q1.push_back(r);
  endtask

  task automatic mon(int k);
    res_t r;
    check("vld_exc_exclusive", 64'(o_vld[k] & o_exc[k]), 64'd0);
    if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
      check("spurious_done", 64'(o_vld[k] | o_exc[k]), 64'd0);
    end else begin
      r = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check("res_vld",   64'(o_vld[k]),   64'(r.vld));
      check("res_exc",   64'(o_exc[k]),   64'(r.exc));
      check("res_cause", 64'(o_cause[k]), 64'(r.cause));
      check("res_dat",   g_dat(k),        r.dat);
    end
  endtask

  always @(negedge sclk) if (srst && (o_vld[0] || o_exc[0])) mon(0);
  always @(negedge sclk) if (srst && (o_vld[1] || o_exc[1])) mon(1);

  // kind: 0 ack, 1 err, 2 ack+err, 3 no response (timeout)
  task automatic issue(int k, bit wre, bit [2:0] fn3, bit [63:0] adr, bit [63:0] dat,
                       bit [63:0] dti, int kind, int nwait);
    mdl_t m;
    int c, tmo;
    tmo = (k == 0) ? 8 : 255;
    m = model((k == 0) ? 32 : 64, wre, fn3, adr, dat, dti, kind);
    @(negedge sclk);
    sena[k] = 1'b1; r_vld[k] = 1'b1; r_wre[k] = wre;
    r_fn3[k] = fn3; r_adr[k] = adr; r_dat[k] = dat;
    #1 check("stall_on_req", 64'(o_stall[k]), 64'd1);
    if (!m.ok || kind == 3) push(k, m.res);
    @(negedge sclk);
    if (!m.ok) begin
      check("no_stb_on_fault", 64'(o_stb[k]), 64'd0);
      check("stall_in_done", 64'(o_stall[k]), 64'd0);
      r_vld[k] = 1'b0;
    end else begin
      c = 0;
      while (o_stb[k] === 1'b1) begin
        c++;
        check("bus_adr", g_adr(k), m.badr);
        check("bus_sel", g_sel(k), 64'(m.sel));
        check("bus_dto", g_dto(k), m.dto);
        check("bus_wre", 64'(o_wre[k]), 64'(wre));
        check("stall_in_wait", 64'(o_stall[k]), 64'd1);
        sena[k] = 1'($urandom);
        if (kind != 3 && c == nwait + 1) begin
          i_ack[k] = (kind != 1);
          i_err[k] = (kind != 0);
          i_dti[k] = dti;
          push(k, m.res);
        end else begin
          i_ack[k] = 1'b0;
          i_err[k] = 1'b0;
          i_dti[k] = {$urandom, $urandom};
        end
        if (c > tmo + 4) begin
          check("stb_bound", 64'(c), 64'(tmo));
          break;
        end
        @(negedge sclk);
      end
      i_ack[k] = 1'b0;
      i_err[k] = 1'b0;
      r_vld[k] = 1'b0;
      check("stb_cycles", 64'(c), 64'((kind == 3) ? tmo : nwait + 1));
      check("stall_in_done", 64'(o_stall[k]), 64'd0);
    end
    sena[k] = 1'b1;
  endtask

  task automatic rand_req(int k);
    bit wre;
    bit [2:0] fn3;
    bit [63:0] adr;
    int r, kind;
    wre = 1'($urandom);
    fn3 = 3'($urandom_range(0, 7));
    adr = (k == 0) ? {32'h0, $urandom} : {$urandom, $urandom};
    if ($urandom_range(0, 3) != 0) adr &= ~((64'd1 << fn3[1:0]) - 64'd1);
    r = $urandom_range(0, 9);
    kind = (r <= 6) ? 0 : (r == 7) ? 1 : (r == 8) ? 2 : ((k == 0) ? 3 : 0);
    issue(k, wre, fn3, adr, {$urandom, $urandom}, {$urandom, $urandom}, kind,
          $urandom_range(0, (k == 0) ? 6 : 4));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sena = '0; r_vld = '0; r_wre = '0; i_ack = '0; i_err = '0;
    r_fn3 = '0; r_adr = '0; r_dat = '0; i_dti = '0;
    repeat (3) @(posedge sclk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_stb",   64'(o_stb[k]),   64'd0);
      check("rst_wre",   64'(o_wre[k]),   64'd0);
      check("rst_sel",   g_sel(k),        64'd0);
      check("rst_dto",   g_dto(k),        64'd0);
      check("rst_adr",   g_adr(k),        64'd0);
      check("rst_vld",   64'(o_vld[k]),   64'd0);
      check("rst_exc",   64'(o_exc[k]),   64'd0);
      check("rst_cause", 64'(o_cause[k]), 64'd0);
      check("rst_dat",   g_dat(k),        64'd0);
      check("rst_stall", 64'(o_stall[k]), 64'd0);
    end
    @(negedge sclk);
    srst = 1'b1;

    // XLEN=32 directed cases
    issue(0, 1'b1, 3'b000, 64'h1003, 64'hA5, 64'h0, 0, 0);          // SB, replicated lanes
    issue(0, 1'b0, 3'b001, 64'h2002, 64'h0, 64'h8001_1234, 0, 3);   // LH, 3 wait cycles
    issue(0, 1'b0, 3'b010, 64'h3001, 64'h0, 64'h0, 0, 0);           // LW misaligned
    issue(0, 1'b1, 3'b010, 64'h40, 64'h1234_5678, 64'h0, 3, 0);     // SW timeout
    issue(0, 1'b0, 3'b100, 64'h11, 64'h0, 64'hDEAD_BEEF, 2, 1);     // LBU ack+err
    issue(0, 1'b0, 3'b011, 64'h100, 64'h0, 64'h0, 0, 0);            // LD on 32-bit
    issue(0, 1'b1, 3'b100, 64'h100, 64'h0, 64'h0, 0, 0);            // store with fn3[2]
    issue(0, 1'b0, 3'b110, 64'h100, 64'h0, 64'h0, 0, 0);            // LWU on 32-bit
    issue(0, 1'b1, 3'b001, 64'h2006, 64'hBEEF, 64'h0, 1, 2);        // SH bus error

    // sena low: a valid request must not be accepted
    @(negedge sclk);
    sena[0] = 1'b0; r_vld[0] = 1'b1; r_fn3[0] = 3'b010; r_adr[0] = 64'h100;
    repeat (3) begin
      #1 check("sena_gate_stall", 64'(o_stall[0]), 64'd0);
      @(negedge sclk);
      check("sena_gate_stb", 64'(o_stb[0]), 64'd0);
    end
    r_vld[0] = 1'b0; sena[0] = 1'b1;

    repeat (40) rand_req(0);

    // XLEN=64 directed cases
    issue(1, 1'b0, 3'b011, 64'h18, 64'h0, 64'h8000_0000_0000_0001, 0, 2);  // LD
    issue(1, 1'b0, 3'b110, 64'h1C, 64'h0, 64'h8000_0000_0000_0000, 0, 0);  // LWU upper word
    issue(1, 1'b1, 3'b011, 64'h28, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 1);  // SD
    issue(1, 1'b0, 3'b000, 64'h7, 64'h0, 64'h80FF_0000_0000_0000, 0, 0);   // LB lane 7

    repeat (30) rand_req(1);

    // Reset in the middle of a bus cycle: stb drops at once, no completion
    @(negedge sclk);
    sena[1] = 1'b1; r_vld[1] = 1'b1; r_wre[1] = 1'b0; r_fn3[1] = 3'b011; r_adr[1] = 64'h20;
    @(negedge sclk);
    check("rst_wait_pre_stb", 64'(o_stb[1]), 64'd1);
    #2;
    r_vld[1] = 1'b0;
    srst = 1'b0;
    #1;
    check("rst_wait_stb",   64'(o_stb[1]),   64'd0);
    check("rst_wait_stall", 64'(o_stall[1]), 64'd0);
    check("rst_wait_sel",   g_sel(1),        64'd0);
    check("rst_wait_adr",   g_adr(1),        64'd0);
    @(negedge sclk);
    srst = 1'b1;
    repeat (3) begin
      @(negedge sclk);
      check("post_rst_stb", 64'(o_stb[1]), 64'd0);
    end

    repeat (3) @(negedge sclk);
    check("q0_drained", 64'(exp_q0.size()), 64'd0);
    check("q1_drained", 64'(exp_q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/t5_lsu.md
T5_LSU -- requirements
Module: t5_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and bus width; legal values are 32 and 64.
REQ-002 SHALL have parameter TMO, default 255, meaning bus timeout in cycles; 0 disables the timeout.
REQ-003 SHALL derive NB=XLEN/8 (byte lanes) and SW=log2(NB) (offset bits).
REQ-004 SHALL have port sclk, input, 1 bit, sole clock; all flops rise on posedge sclk.
REQ-005 SHALL have port srst, input, 1 bit, reset, asynchronous, active-low.
REQ-006 SHALL have port sena, input, 1 bit, pipeline enable; gates request acceptance only.
REQ-007 SHALL have port req_vld, input, 1 bit, memory request valid; held stable while lsu_stall=1.
REQ-008 SHALL have port req_wre, input, 1 bit: 1=store, 0=load.
REQ-009 SHALL have port req_fn3, input, 3 bits, RISC-V funct3 access size/sign.
REQ-010 SHALL have port req_adr, input, XLEN bits, effective byte address.
REQ-011 SHALL have port req_dat, input, XLEN bits, store data (low bytes significant).
REQ-012 SHALL have port dwb_adr, output, XLEN-SW bits, lane-aligned bus address (req_adr[XLEN-1:SW]).
REQ-013 SHALL have ports dwb_dto (output, XLEN), dwb_sel (output, NB), dwb_wre (output, 1) and dwb_stb (output, 1), Wishbone master signals.
REQ-014 SHALL have ports dwb_dti (input, XLEN), dwb_ack (input, 1) and dwb_err (input, 1), Wishbone slave responses.
REQ-015 SHALL have port lsu_stall, output, 1 bit, hold-pipeline indication.
REQ-016 SHALL have ports lsu_vld (output, 1), completion pulse, and lsu_dat (output, XLEN), extended load result.
REQ-017 SHALL have ports lsu_exc (output, 1), exception pulse, and lsu_cause (output, 4 bits), RISC-V mcause code.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT and DONE.
REQ-019 SHALL accept a request in IDLE when sena=1 and req_vld=1, registering the address, sel, dto, wre and fn3.
REQ-020 SHALL, on an aligned and legal request: at the accepting edge set dwb_stb=1 and go IDLE->WAIT.
REQ-021 SHALL, on a misaligned or illegal request: issue no bus cycle and go IDLE->DONE with lsu_exc=1.
REQ-022 SHALL drive dwb_sel = ((1<<size)-1) << req_adr[SW-1:0], with size 1/2/4/8 for fn3[1:0]=00/01/10/11.
REQ-023 SHALL treat an access as misaligned when the address is not a multiple of its size; cause 4 for a load, 6 for a store.
REQ-024 SHALL treat fn3 as illegal (cause 2) when fn3 is 111, when fn3 is 011 with XLEN=32, or when a store has fn3[2]=1; XLEN=32 with fn3=110 is also illegal.
REQ-025 SHALL drive dwb_dto as store data replicated across all lanes: byte NB times, half NB/2 times, word NB/4 times, dword once.
REQ-026 SHALL, in WAIT, hold dwb_adr, dwb_sel, dwb_dto, dwb_wre and dwb_stb stable, independent of sena.
REQ-027 SHALL, in WAIT on dwb_ack=1 and dwb_err=0: at the next edge set dwb_stb=0, go WAIT->DONE and set lsu_vld=1.
REQ-028 SHALL, in WAIT on dwb_err=1 (err wins over ack): go WAIT->DONE with lsu_exc=1; cause 5 for a load, 7 for a store.
REQ-029 SHALL, in WAIT with TMO>0, count stb-high cycles and on reaching TMO treat the access as dwb_err; the counter clears on entering WAIT.
REQ-030 SHALL form lsu_dat on a load as dwb_dti >> (8*offset), then sign-extend (fn3[2]=0) or zero-extend (fn3[2]=1) from the access size; lsu_dat=0 for a store.
REQ-031 SHALL register lsu_dat, lsu_vld, lsu_exc and lsu_cause so they are valid in DONE only; lsu_vld and lsu_exc are never both 1.
REQ-032 SHALL return DONE->IDLE unconditionally after one cycle and accept no request while in DONE.
REQ-033 SHALL drive lsu_stall = (state==WAIT) | (state==IDLE & sena & req_vld), combinationally.

Reset
REQ-034 SHALL, while srst=0, immediately force state IDLE; dwb_stb, dwb_wre, dwb_sel, dwb_dto, dwb_adr, lsu_vld, lsu_exc, lsu_cause, lsu_dat and the counter to 0.
REQ-035 SHALL, on reset during WAIT, abandon the bus cycle and produce no lsu_vld or lsu_exc.

Verification
REQ-036 SHALL verify: XLEN=32, SB adr 0x1003 dat 0xA5 -> dwb_adr 0x400, dwb_sel 0x8, dwb_dto 0xA5A5A5A5, dwb_wre=1; ack -> lsu_vld for 1 cycle.
REQ-037 SHALL verify: LH adr 0x2002, ack after 3 wait cycles with dwb_dti 0x80011234 -> dwb_sel 0xC, dwb_stb high 4 cycles, lsu_dat 0xFFFF8001.
REQ-038 SHALL verify: LW adr 0x3001 -> dwb_stb stays 0; lsu_exc=1, lsu_cause 4 for 1 cycle; lsu_stall high 1 cycle.
REQ-039 SHALL verify: TMO=8, SW adr 0x40 with no ack -> dwb_stb high exactly 8 cycles, then lsu_exc=1, lsu_cause 7.
REQ-040 SHALL verify: LBU adr 0x11 with dwb_ack=1 and dwb_err=1 in the same cycle -> lsu_exc=1, lsu_cause 5, lsu_vld=0.
REQ-041 SHALL verify: XLEN=64, LD adr 0x18 dti 0x8000000000000001 -> dwb_sel 0xFF, lsu_dat unchanged; srst=0 during WAIT -> dwb_stb 0 with no clock edge.
